// File: rtl/ternary_neuron_accum.sv
// ---------------------------------------------------------------------------
// ternary_neuron_accum
// Ternary-neuron back end that sits downstream of the approximate popcount
// stages. It accumulates the signed difference (pos - neg) over a multi-chunk
// vector with saturation applied on every beat. It then thresholds the total
// into a +1/0/-1 activation and returns the result through a valid/ready
// handshake.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   input beat handshake (in_ready is registered)
//   in_pos, in_neg        unsigned popcounts of +1 / -1 weighted inputs
//   in_last               final chunk of this neuron's vector
//   out_valid / out_ready result handshake
//   out_act               01 = +1, 00 = 0, 11 = -1
//   out_sum               signed saturated accumulated sum
//   out_sat               saturation occurred during this evaluation
//   out_trunc             evaluation ended at MAX_CHUNKS without in_last
// ---------------------------------------------------------------------------
module ternary_neuron_accum #(
   parameter int unsigned CNT_W      = 6,
   parameter int unsigned ACC_W      = 10,
   parameter int unsigned MAX_CHUNKS = 16,
   parameter int          THR_HI     = 8,
   parameter int          THR_LO     = -8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CNT_W-1:0] in_pos,
   input  logic [CNT_W-1:0] in_neg,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_act,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_sat,
   output logic             out_trunc
);

   localparam int unsigned CHK_W = $clog2(MAX_CHUNKS) + 1;
   localparam int unsigned DLT_W = ACC_W + 1;
   localparam int unsigned SUM_W = ACC_W + 2;

   localparam logic signed [ACC_W-1:0] THR_HI_V = ACC_W'(THR_HI);
   localparam logic signed [ACC_W-1:0] THR_LO_V = ACC_W'(THR_LO);
   localparam logic [CHK_W-1:0]        CNT_MAX  = CHK_W'(MAX_CHUNKS);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   // State and datapath registers
   state_t                  r_state;
   logic signed [ACC_W-1:0] r_acc;
   logic [CHK_W-1:0]        r_cnt;
   logic                    r_sat_acc;
   logic                    r_in_ready;
   logic                    r_out_valid;
   logic [1:0]              r_out_act;
   logic [ACC_W-1:0]        r_out_sum;
   logic                    r_out_sat;
   logic                    r_out_trunc;

   // Next-state values
   state_t                  w_state_nxt;
   logic signed [ACC_W-1:0] w_acc_nxt;
   logic [CHK_W-1:0]        w_cnt_nxt;
   logic                    w_sat_acc_nxt;
   logic                    w_in_ready_nxt;
   logic                    w_out_valid_nxt;
   logic [1:0]              w_out_act_nxt;
   logic [ACC_W-1:0]        w_out_sum_nxt;
   logic                    w_out_sat_nxt;
   logic                    w_out_trunc_nxt;

   // Beat datapath
   logic                    w_accept;
   logic                    w_in_accum;
   logic signed [DLT_W-1:0] w_delta;
   logic signed [ACC_W-1:0] w_base;
   logic signed [SUM_W-1:0] w_sum;
   logic [2:0]              w_top;
   logic                    w_ovf;
   logic signed [ACC_W-1:0] w_acc_sat;
   logic [CHK_W-1:0]        w_cnt_inc;
   logic                    w_at_max;
   logic                    w_end;
   logic                    w_trunc;
   logic                    w_sat_any;
   logic [1:0]              w_act;

   assign w_accept   = in_valid && r_in_ready;
   assign w_in_accum = (r_state == ST_ACCUM);

   // Popcounts are unsigned; zero-extend before the signed subtract
   assign w_delta = $signed(DLT_W'(in_pos)) - $signed(DLT_W'(in_neg));

   // A first beat from IDLE starts from zero regardless of any stale sum
   assign w_base = w_in_accum ? r_acc : '0;
   assign w_sum  = SUM_W'(w_base) + SUM_W'(w_delta);

   // Overflow when the bits above the ACC_W sign bit disagree with it
   assign w_top = w_sum[SUM_W-1:ACC_W-1];
   assign w_ovf = (w_top != 3'b000) && (w_top != 3'b111);

   // Per-beat clamp to the ACC_W two's-complement range
   always_comb begin
      w_acc_sat = w_sum[ACC_W-1:0];
      if (w_ovf) begin
         if (w_sum[SUM_W-1]) w_acc_sat = {1'b1, {(ACC_W-1){1'b0}}};
         else                w_acc_sat = {1'b0, {(ACC_W-1){1'b1}}};
      end
   end

   assign w_cnt_inc = (w_in_accum ? r_cnt : '0) + CHK_W'(1);
   assign w_at_max  = (w_cnt_inc == CNT_MAX);
   assign w_end     = in_last || w_at_max;
   assign w_trunc   = w_at_max && !in_last;
   assign w_sat_any = (w_in_accum && r_sat_acc) || w_ovf;

   // Signed threshold compare on the post-clamp sum
   always_comb begin
      w_act = 2'b00;
      if (w_acc_sat >= THR_HI_V)      w_act = 2'b01;
      else if (w_acc_sat <= THR_LO_V) w_act = 2'b11;
   end

   // Next-state and output logic
   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_acc;
      w_cnt_nxt       = r_cnt;
      w_sat_acc_nxt   = r_sat_acc;
      w_out_valid_nxt = r_out_valid;
      w_out_act_nxt   = r_out_act;
      w_out_sum_nxt   = r_out_sum;
      w_out_sat_nxt   = r_out_sat;
      w_out_trunc_nxt = r_out_trunc;

      case (r_state)
         ST_IDLE, ST_ACCUM: begin
            if (w_accept) begin
               w_acc_nxt     = w_acc_sat;
               w_cnt_nxt     = w_cnt_inc;
               w_sat_acc_nxt = w_sat_any;
               if (w_end) begin
                  w_state_nxt     = ST_RESULT;
                  w_out_valid_nxt = 1'b1;
                  w_out_sum_nxt   = w_acc_sat;
                  w_out_sat_nxt   = w_sat_any;
                  w_out_trunc_nxt = w_trunc;
                  w_out_act_nxt   = w_act;
               end else begin
                  w_state_nxt = ST_ACCUM;
               end
            end
         end
         ST_RESULT: begin
            // Result fields keep their values after the handshake
            if (r_out_valid && out_ready) begin
               w_state_nxt     = ST_IDLE;
               w_out_valid_nxt = 1'b0;
               w_acc_nxt       = '0;
               w_cnt_nxt       = '0;
               w_sat_acc_nxt   = 1'b0;
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_out_valid_nxt = 1'b0;
         end
      endcase

      w_in_ready_nxt = (w_state_nxt != ST_RESULT);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_sat_acc   <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_act   <= 2'b00;
         r_out_sum   <= '0;
         r_out_sat   <= 1'b0;
         r_out_trunc <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_cnt       <= w_cnt_nxt;
         r_sat_acc   <= w_sat_acc_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_act   <= w_out_act_nxt;
         r_out_sum   <= w_out_sum_nxt;
         r_out_sat   <= w_out_sat_nxt;
         r_out_trunc <= w_out_trunc_nxt;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_act   = r_out_act;
   assign out_sum   = r_out_sum;
   assign out_sat   = r_out_sat;
   assign out_trunc = r_out_trunc;

endmodule

// File: tb/tb_ternary_neuron_accum.sv
// ---------------------------------------------------------------------------
// tb_ternary_neuron_accum
// Directed bench for ternary_neuron_accum with hand-computed expectations.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_ternary_neuron_accum;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] in_pos;
   logic [5:0] in_neg;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_act;
   logic [9:0] out_sum;
   logic       out_sat;
   logic       out_trunc;

   int total;
   int bad;

   ternary_neuron_accum #(
      .CNT_W(6), .ACC_W(10), .MAX_CHUNKS(16), .THR_HI(8), .THR_LO(-8)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_act(out_act), .out_sum(out_sum),
      .out_sat(out_sat), .out_trunc(out_trunc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat for one cycle; in_valid stays high for back-to-back use
   task automatic beat(input int p, input int n, input logic l);
      in_valid = 1'b1;
      in_pos   = 6'(p);
      in_neg   = 6'(n);
      in_last  = l;
      tick();
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_pos   = '0;
      in_neg   = '0;
   endtask

   // Complete the result handshake (no checking here)
   task automatic release_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; out_ready = 1'b0;
      idle_inputs();
      #12;
      total++;
      if ({in_ready, out_valid, out_act, out_sum, out_sat, out_trunc} !== 15'b0) begin
         bad++;
         $display("FAIL reset_outputs got rdy=%b v=%b act=%b sum=%0d sat=%b tr=%b exp all 0",
                  in_ready, out_valid, out_act, out_sum, out_sat, out_trunc);
      end
      rst_n = 1'b1;
      tick();
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_release_ready got %b exp 1", in_ready);
      end
   endtask

   task automatic test_single();
      beat(20, 5, 1'b1);
      idle_inputs();
      total++;
      if (out_valid !== 1'b1 || out_sum !== 10'd15 || out_act !== 2'b01 ||
          out_sat !== 1'b0 || out_trunc !== 1'b0 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL single_result got v=%b sum=%0d act=%b sat=%b tr=%b rdy=%b exp 1/15/01/0/0/0",
                  out_valid, $signed(out_sum), out_act, out_sat, out_trunc, in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (out_valid !== 1'b1 || out_sum !== 10'd15 || out_act !== 2'b01 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_hold[%0d] got v=%b sum=%0d act=%b rdy=%b exp 1/15/01/0",
                     i, out_valid, $signed(out_sum), out_act, in_ready);
         end
      end
      release_result();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 10'd15 || out_act !== 2'b01) begin
         bad++;
         $display("FAIL single_handshake got v=%b rdy=%b sum=%0d act=%b exp 0/1/15/01",
                  out_valid, in_ready, $signed(out_sum), out_act);
      end
   endtask

   task automatic test_three_beats();
      beat(3, 7, 1'b0);
      beat(10, 4, 1'b0);
      beat(0, 9, 1'b1);
      idle_inputs();
      total++;
      if (out_valid !== 1'b1 || out_sum !== 10'(-7) || out_act !== 2'b00) begin
         bad++;
         $display("FAIL three_zero got v=%b sum=%0d act=%b exp 1/-7/00",
                  out_valid, $signed(out_sum), out_act);
      end
      release_result();
      beat(3, 7, 1'b0);
      beat(10, 4, 1'b0);
      beat(0, 12, 1'b1);
      idle_inputs();
      total++;
      if (out_valid !== 1'b1 || out_sum !== 10'(-10) || out_act !== 2'b11) begin
         bad++;
         $display("FAIL three_neg got v=%b sum=%0d act=%b exp 1/-10/11",
                  out_valid, $signed(out_sum), out_act);
      end
      release_result();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 16; i++) beat(63, 0, (i == 15));
      idle_inputs();
      total++;
      if (out_valid !== 1'b1 || out_sum !== 10'd511 || out_sat !== 1'b1 ||
          out_trunc !== 1'b0 || out_act !== 2'b01) begin
         bad++;
         $display("FAIL sat_pos got v=%b sum=%0d sat=%b tr=%b act=%b exp 1/511/1/0/01",
                  out_valid, $signed(out_sum), out_sat, out_trunc, out_act);
      end
      release_result();
      for (int i = 0; i < 8; i++) beat(0, 63, (i == 7));
      idle_inputs();
      total++;
      if (out_valid !== 1'b1 || out_sum !== 10'(-504) || out_sat !== 1'b0 ||
          out_trunc !== 1'b0 || out_act !== 2'b11) begin
         bad++;
         $display("FAIL sat_fresh got v=%b sum=%0d sat=%b tr=%b act=%b exp 1/-504/0/0/11",
                  out_valid, $signed(out_sum), out_sat, out_trunc, out_act);
      end
      release_result();
   endtask

   task automatic test_truncation();
      for (int i = 0; i < 16; i++) beat(1, 0, 1'b0);
      total++;
      if (out_valid !== 1'b1 || out_sum !== 10'd16 || out_trunc !== 1'b1 ||
          out_act !== 2'b01 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL trunc_result got v=%b sum=%0d tr=%b act=%b rdy=%b exp 1/16/1/01/0",
                  out_valid, $signed(out_sum), out_trunc, out_act, in_ready);
      end
      // 17th beat waits while the result is pending
      beat(5, 0, 1'b1);
      tick();
      total++;
      if (out_valid !== 1'b1 || out_sum !== 10'd16 || out_trunc !== 1'b1) begin
         bad++;
         $display("FAIL trunc_stall got v=%b sum=%0d tr=%b exp 1/16/1",
                  out_valid, $signed(out_sum), out_trunc);
      end
      release_result();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 10'd16) begin
         bad++;
         $display("FAIL trunc_handshake got v=%b rdy=%b sum=%0d exp 0/1/16",
                  out_valid, in_ready, $signed(out_sum));
      end
      tick();
      idle_inputs();
      total++;
      if (out_valid !== 1'b1 || out_sum !== 10'd5 || out_trunc !== 1'b0 || out_act !== 2'b00) begin
         bad++;
         $display("FAIL trunc_next_beat got v=%b sum=%0d tr=%b act=%b exp 1/5/0/00",
                  out_valid, $signed(out_sum), out_trunc, out_act);
      end
      release_result();
   endtask

   task automatic test_reset_mid();
      beat(4, 1, 1'b0);
      beat(2, 0, 1'b0);
      idle_inputs();
      for (int i = 0; i < 4; i++) tick();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL gap_hold got v=%b rdy=%b exp 0/1", out_valid, in_ready);
      end
      #3 rst_n = 1'b0;
      #1;
      total++;
      if ({in_ready, out_valid, out_act, out_sum, out_sat, out_trunc} !== 15'b0) begin
         bad++;
         $display("FAIL reset_accum got rdy=%b v=%b act=%b sum=%0d sat=%b tr=%b exp all 0",
                  in_ready, out_valid, out_act, out_sum, out_sat, out_trunc);
      end
      #2 rst_n = 1'b1;
      tick();
      beat(2, 2, 1'b1);
      idle_inputs();
      total++;
      if (out_valid !== 1'b1 || out_sum !== 10'd0 || out_act !== 2'b00 || out_sat !== 1'b0) begin
         bad++;
         $display("FAIL reset_restart got v=%b sum=%0d act=%b sat=%b exp 1/0/00/0",
                  out_valid, $signed(out_sum), out_act, out_sat);
      end
      // Reset while a result is held in RESULT
      #3 rst_n = 1'b0;
      #1;
      total++;
      if ({in_ready, out_valid, out_act, out_sum, out_sat, out_trunc} !== 15'b0) begin
         bad++;
         $display("FAIL reset_result got rdy=%b v=%b act=%b sum=%0d sat=%b tr=%b exp all 0",
                  in_ready, out_valid, out_act, out_sum, out_sat, out_trunc);
      end
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_thresholds();
      int         p_tab [6] = '{8, 0, 7, 0, 9, 4};
      int         n_tab [6] = '{0, 8, 0, 7, 0, 13};
      logic [9:0] s_tab [6] = '{10'd8, 10'h3F8, 10'd7, 10'h3F9, 10'd9, 10'h3F7};
      logic [1:0] a_tab [6] = '{2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 2'b11};
      for (int i = 0; i < 6; i++) begin
         beat(p_tab[i], n_tab[i], 1'b1);
         idle_inputs();
         total++;
         if (out_valid !== 1'b1 || out_sum !== s_tab[i] || out_act !== a_tab[i]) begin
            bad++;
            $display("FAIL threshold[%0d] got v=%b sum=%0d act=%b exp 1/%0d/%b",
                     i, out_valid, $signed(out_sum), out_act, $signed(s_tab[i]), a_tab[i]);
         end
         release_result();
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single();
      test_three_beats();
      test_saturation();
      test_truncation();
      test_reset_mid();
      test_thresholds();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ternary_neuron_accum.md
Name: ternary_neuron_accum

Overview:
Sequential ternary-neuron back end that sits directly downstream of the approximate popcount stages. Each accepted beat carries a positive-weight count and a negative-weight count, each from one 35-input popcount instance. The block accumulates the signed difference (pos - neg) over a multi-chunk input vector, then compares the total against two thresholds. It emits a ternary activation (+1/0/-1) plus the saturated sum through a valid/ready handshake.

Parameters:
CNT_W, 6, width of each popcount input.
ACC_W, 10, signed accumulator width (two's complement).
MAX_CHUNKS, 16, maximum beats per neuron evaluation; counter width is clog2(MAX_CHUNKS)+1.
THR_HI, 8, signed ACC_W threshold; sum >= THR_HI gives activation +1.
THR_LO, -8, signed ACC_W threshold; sum <= THR_LO gives activation -1. THR_LO < THR_HI is required.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream beat valid
in_ready  out  1  block can accept a beat
in_pos  in  CNT_W  popcount of inputs with +1 weight (unsigned)
in_neg  in  CNT_W  popcount of inputs with -1 weight (unsigned)
in_last  in  1  final chunk of this neuron's vector
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_act  out  2  ternary activation: 01=+1, 00=0, 11=-1
out_sum  out  ACC_W  signed saturated accumulated sum
out_sat  out  1  saturation occurred during this evaluation
out_trunc  out  1  evaluation forced to end at MAX_CHUNKS without in_last

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, chunk_cnt=0. in_ready=0 during reset, 1 after release. out_valid=0, out_act=00, out_sum=0, out_sat=0, out_trunc=0.
- States are IDLE, ACCUM and RESULT. in_ready=1 in IDLE/ACCUM and 0 in RESULT. in_ready is a registered state decode and never depends combinationally on in_valid.
- A beat is accepted when in_valid && in_ready at the rising edge.
- Per-beat delta = zero-extend(in_pos) - zero-extend(in_neg), computed at ACC_W+1 bits.
- Beat accepted in IDLE: acc <= sat(delta), chunk_cnt <= 1, sat flag <= (saturation this beat). Any prior sum is ignored.
- Beat accepted in ACCUM: acc <= sat(acc + delta), chunk_cnt++, sat flag is sticky OR.
- sat(): clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. The clamp is evaluated per beat, so a later opposite delta starts from the clamped value.
- End of evaluation is the accepted beat with in_last=1, or the accepted beat that makes chunk_cnt == MAX_CHUNKS. In the second case trunc=1, unless in_last is also 1 on that beat.
- On end: state <= RESULT. In the same edge, out_sum <= new acc value, out_sat <= sticky flag, out_trunc <= trunc, out_act <= compare(new acc), out_valid <= 1.
- Latency: last beat accepted at edge k puts the result on the outputs after edge k, i.e. one cycle.
- Non-last beat: IDLE -> ACCUM; ACCUM stays in ACCUM.
- compare(): if sum >= THR_HI then 01; else if sum <= THR_LO then 11; else 00. The comparison is signed.
- In RESULT, all out_* are held stable until out_valid && out_ready. On that edge, out_valid <= 0, state <= IDLE, and acc/chunk_cnt are cleared. out_act/out_sum/out_sat/out_trunc keep their last values.
- The next beat is accepted no earlier than the cycle after the handshake, giving one bubble per neuron.
- in_valid low in ACCUM: hold state, no change.
- in_last asserted on the first beat from IDLE: single-chunk evaluation, IDLE -> RESULT directly.
- Inputs up to 2^CNT_W-1 are legal. The approximate upstream may exceed 35; no clamping is applied.
- Reset asserted mid-evaluation or in RESULT: the in-flight evaluation is discarded and outputs return to their reset values immediately.

Test Plan:
- Single beat in_pos=20, in_neg=5, in_last=1 -> next cycle out_valid=1, out_sum=15, out_act=01, out_sat=0, out_trunc=0. out_ready held low for 3 cycles: outputs stable and in_ready=0. out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Three beats (3,7), (10,4), (0,9) with last on the third -> out_sum=-7, out_act=00. Repeat with third beat (0,12) -> out_sum=-10, out_act=11.
- Sixteen beats of (63,0), last on the 16th -> out_sum=511, out_sat=1, out_trunc=0, out_act=01. Then (0,63) repeated 8 times with last -> out_sum=-504, out_sat=0.
- Sixteen beats of (1,0) with in_last never asserted -> forced end after the 16th, out_sum=16, out_trunc=1. The 17th beat is presented but not accepted until after the handshake.
- Two beats accepted, in_valid gapped 4 cycles, then rst_n pulsed low mid-cycle -> all outputs 0 immediately. Next single beat (2,2,last) -> out_sum=0, out_act=00.
- Boundary thresholds: sum exactly 8 -> 01; exactly -8 -> 11; 7 and -7 -> 00.
